// File: rtl/stream_upsizer_if.sv
// Handshake bundle for stream_upsizer: narrow upstream side and wide downstream side.
// Packet signals appear only when STREAM_UPSIZER_LAST_EN is defined.
interface stream_upsizer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  localparam int OW = IN_WIDTH * RATIO;
  localparam int CW = $clog2(RATIO);

  logic [IN_WIDTH-1:0] up_bus;
  logic                up_val;
  logic                up_rdy;
  logic [OW-1:0]       dn_bus;
  logic                dn_val;
  logic                dn_rdy;

`ifdef STREAM_UPSIZER_LAST_EN
  logic                up_last;
  logic                dn_last;
  logic [CW:0]         dn_cnt;

  modport master (
    output up_bus, up_val, up_last, dn_rdy,
    input  up_rdy, dn_bus, dn_val, dn_last, dn_cnt
  );

  modport slave (
    input  up_bus, up_val, up_last, dn_rdy,
    output up_rdy, dn_bus, dn_val, dn_last, dn_cnt
  );
`else
  modport master (
    output up_bus, up_val, dn_rdy,
    input  up_rdy, dn_bus, dn_val
  );

  modport slave (
    input  up_bus, up_val, dn_rdy,
    output up_rdy, dn_bus, dn_val
  );
`endif
endinterface

// File: rtl/stream_upsizer.sv
// Valid/ready width up-converter packing RATIO little-endian beats into one registered word.
// Define STREAM_UPSIZER_LAST_EN to add up_last / dn_last / dn_cnt for early-closed words.
module stream_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic            clk,
  input  logic            rst,
  stream_upsizer_if.slave io
);
  localparam int OW = IN_WIDTH * RATIO;
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0] cnt;
  logic [OW-1:0] acc;
  logic [OW-1:0] merged;
  logic [OW-1:0] dn_bus_q;
  logic          dn_val_q;
  logic          closing;
  logic          up_rdy;
  logic          up_acc;
  logic          dn_acc;

`ifdef STREAM_UPSIZER_LAST_EN
  logic          dn_last_q;
  logic [CW:0]   dn_cnt_q;

  assign closing = (cnt == LAST_LANE) | io.up_last;
`else
  assign closing = (cnt == LAST_LANE);
`endif

  // Only a closing beat needs the output register, so only it can be stalled.
  assign up_rdy = ~closing | ~dn_val_q | io.dn_rdy;
  assign up_acc = io.up_val & up_rdy;
  assign dn_acc = dn_val_q & io.dn_rdy;

  // Lanes above cnt are still zero in acc, so an early close leaves them cleared.
  always_comb begin
    merged = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt == CW'(i)) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = io.up_bus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      dn_bus_q  <= '0;
      dn_val_q  <= 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
      dn_last_q <= 1'b0;
      dn_cnt_q  <= '0;
`endif
    end else begin
      if (dn_acc) begin
        dn_val_q <= 1'b0;
      end
      if (up_acc) begin
        if (closing) begin
          dn_bus_q  <= merged;
          dn_val_q  <= 1'b1;
          cnt       <= '0;
          acc       <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
          dn_last_q <= io.up_last;
          dn_cnt_q  <= {1'b0, cnt} + (CW + 1)'(1);
`endif
        end else begin
          acc <= merged;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign io.up_rdy  = up_rdy;
  assign io.dn_bus  = dn_bus_q;
  assign io.dn_val  = dn_val_q;
`ifdef STREAM_UPSIZER_LAST_EN
  assign io.dn_last = dn_last_q;
  assign io.dn_cnt  = dn_cnt_q;
`endif
endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based packing model.
module tb_stream_upsizer;
  localparam int IN_WIDTH = 8;
  localparam int RATIO    = 4;
  localparam int OW       = IN_WIDTH * RATIO;
  localparam int CW       = $clog2(RATIO);
`ifdef STREAM_UPSIZER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_upsizer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) io ();

  stream_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats gathered so far plus the word the output should be holding.
  logic [IN_WIDTH-1:0] m_beats[$];
  bit                  m_val  = 1'b0;
  logic [OW-1:0]       m_word = '0;
  int                  m_lanes = 0;
  bit                  m_last  = 1'b0;

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] packBeats();
    logic [OW-1:0] w;
    w = '0;
    foreach (m_beats[k]) w = w | (OW'(m_beats[k]) << (k * IN_WIDTH));
    return w;
  endfunction

  task automatic checkOutput();
    checkEq("dn_val", 64'(io.dn_val), 64'(m_val));
    if (m_val) begin
      checkEq("dn_bus", 64'(io.dn_bus), 64'(m_word));
`ifdef STREAM_UPSIZER_LAST_EN
      checkEq("dn_cnt", 64'(io.dn_cnt), 64'(m_lanes));
      checkEq("dn_last", 64'(io.dn_last), 64'(m_last));
`endif
    end
  endtask

  // One clock cycle: drive inputs, check up_rdy, advance the model at the edge, check outputs.
  task automatic applyStimulus(input bit val, input logic [IN_WIDTH-1:0] b, input bit rdy,
                               input bit last, input bit do_rst, output bit accepted);
    bit exp_rdy;
    bit close_try;
    @(negedge clk);
    io.up_val = val;
    io.up_bus = b;
    io.dn_rdy = rdy;
`ifdef STREAM_UPSIZER_LAST_EN
    io.up_last = last;
`endif
    rst = do_rst;
    #1;
    close_try = (m_beats.size() == RATIO - 1) || (LAST_EN && last);
    exp_rdy   = !close_try || !m_val || rdy;
    checkEq("up_rdy", 64'(io.up_rdy), 64'(exp_rdy));
    @(posedge clk);
    accepted = val && exp_rdy && !do_rst;
    if (do_rst) begin
      m_beats.delete();
      m_val = 1'b0;
      m_word = '0;
      m_lanes = 0;
      m_last = 1'b0;
    end else begin
      if (m_val && rdy) m_val = 1'b0;
      if (accepted) begin
        m_beats.push_back(b);
        if (m_beats.size() == RATIO || (LAST_EN && last)) begin
          m_word  = packBeats();
          m_lanes = m_beats.size();
          m_last  = LAST_EN && last;
          m_val   = 1'b1;
          m_beats.delete();
        end
      end
    end
    #1;
    checkOutput();
  endtask

  bit acc;
  int tries;

  initial begin
    io.up_val = 1'b0;
    io.up_bus = '0;
    io.dn_rdy = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
    io.up_last = 1'b0;
`endif

    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    checkEq("reset dn_val", 64'(io.dn_val), 64'd0);
    checkEq("reset dn_bus", 64'(io.dn_bus), 64'd0);

    // Test 1: one full word.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, IN_WIDTH'(8'h11 * i), 1'b1, 1'b0, 1'b0, acc);
    checkEq("t1 dn_bus", 64'(io.dn_bus), 64'h44332211);
    checkEq("t1 dn_val", 64'(io.dn_val), 64'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    checkEq("t1 dn_val one cycle", 64'(io.dn_val), 64'd0);

    // Test 2: back-to-back words, never stalled.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, IN_WIDTH'(i), 1'b1, 1'b0, 1'b0, acc);
      checkEq("t2 accepted", 64'(acc), 64'd1);
      if (i == 4) checkEq("t2 word0", 64'(io.dn_bus), 64'h04030201);
      if (i == 8) checkEq("t2 word1", 64'(io.dn_bus), 64'h08070605);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Test 3 / 5: closing beat waits on a held word, then loads on the consuming edge.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, IN_WIDTH'(8'hA0 + i), 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, IN_WIDTH'(8'hB0 + i), 1'b0, 1'b0, 1'b0, acc);
      checkEq("t3 partial accepted", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, acc);
      checkEq("t3 stalled", 64'(acc), 64'd0);
      checkEq("t3 held word", 64'(io.dn_bus), 64'hA3A2A1A0);
    end
    applyStimulus(1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, acc);
    checkEq("t5 accepted", 64'(acc), 64'd1);
    checkEq("t5 dn_val", 64'(io.dn_val), 64'd1);
    checkEq("t5 dn_bus", 64'(io.dn_bus), 64'hB3B2B1B0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Test 4: reset mid-word discards partial beats; reset wins over a concurrent beat.
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, IN_WIDTH'(i), 1'b1, 1'b0, 1'b0, acc);
    checkEq("t4 dn_bus", 64'(io.dn_bus), 64'h04030201);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), IN_WIDTH'($urandom), ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0), acc);
    end

`ifdef STREAM_UPSIZER_LAST_EN
    // Test 6: early close with up_last, then next word restarts at lane 0.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b1, 1'b0, acc);
    checkEq("t6 dn_bus", 64'(io.dn_bus), 64'h00006655);
    checkEq("t6 dn_cnt", 64'(io.dn_cnt), 64'd2);
    checkEq("t6 dn_last", 64'(io.dn_last), 64'd1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, IN_WIDTH'(8'h70 + i), 1'b1, 1'b0, 1'b0, acc);
    checkEq("t6 next word", 64'(io.dn_bus), 64'h74737271);
    checkEq("t6 next dn_cnt", 64'(io.dn_cnt), 64'd4);
    checkEq("t6 next dn_last", 64'(io.dn_last), 64'd0);
`endif

    // Drain: a held word must be released within a bounded number of ready cycles.
    tries = 0;
    while (m_val && tries < 8) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      tries++;
    end
    checkEq("drain done", 64'(io.dn_val), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
